spi_sram_arbiter: RTL and testbench

SPI_SRAM_ARBITER -- requirements
Module: spi_sram_arbiter

---
 rtl/spi_sram_arbiter.sv | 156 +++++++++++++++
 tb/tb_spi_sram_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_sram_arbiter.sv
// Two-master (ibus read-only, dbus read/write) arbiter in front of a single SPI SRAM controller.
// Fair round-robin on ties, one-cycle release gap after every slave transfer, watchdog abort.
module spi_sram_arbiter #(
    parameter int unsigned TIMEOUT = 100
) (
    input  logic        clk,
    input  logic        rst,
    // ibus (read-only)
    input  logic        i_cyc,
    input  logic [13:0] i_adr,
    output logic [31:0] i_rdt,
    output logic        i_ack,
    output logic        i_err,
    // dbus
    input  logic        d_cyc,
    input  logic [13:0] d_adr,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_dat,
    output logic [31:0] d_rdt,
    output logic        d_ack,
    output logic        d_err,
    // SPI SRAM controller side
    output logic        s_cyc,
    output logic [13:0] s_adr,
    output logic        s_we,
    output logic [3:0]  s_sel,
    output logic [31:0] s_dat,
    input  logic [31:0] s_rdt,
    input  logic        s_ack,
    // status
    output logic        busy
);

    localparam int unsigned WDW = 8;
    localparam int unsigned SW  = 4;
    localparam int unsigned DW  = 32;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             grant;
    logic             grant_nxt;
    logic             last_grant;
    logic [WDW-1:0]   wd;
    logic             timeout_c;
    logic             gnt_cyc_c;
    logic             enter_busy_c;

    assign timeout_c    = (wd == WDW'(TIMEOUT));
    assign enter_busy_c = (state == ST_IDLE) && (state_nxt == ST_BUSY);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant selection; ties go to the master not served last
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            ST_IDLE: begin
                if (i_cyc || d_cyc) begin
                    state_nxt = ST_BUSY;
                    if (i_cyc && d_cyc) begin
                        grant_nxt = ~last_grant;
                    end else begin
                        grant_nxt = d_cyc ? GNT_D : GNT_I;
                    end
                end
            end
            ST_BUSY: begin
                if (s_ack || timeout_c) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant, fairness history and watchdog, all captured on entry to BUSY
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grant      <= GNT_I;
            last_grant <= GNT_I;
            wd         <= '0;
        end else if (enter_busy_c) begin
            grant      <= grant_nxt;
            last_grant <= grant_nxt;
            wd         <= '0;
        end else if (state == ST_BUSY) begin
            wd         <= wd + WDW'(1);
        end
    end

    // Handshake outputs; a master that dropped cyc gets neither ack nor err
    always_comb begin
        s_cyc     = 1'b0;
        busy      = 1'b0;
        i_ack     = 1'b0;
        d_ack     = 1'b0;
        i_err     = 1'b0;
        d_err     = 1'b0;
        gnt_cyc_c = 1'b0;
        if (state != ST_IDLE) begin
            busy = 1'b1;
        end
        if (state == ST_BUSY) begin
            s_cyc     = 1'b1;
            gnt_cyc_c = (grant == GNT_D) ? d_cyc : i_cyc;
            if (s_ack) begin
                i_ack = gnt_cyc_c && (grant == GNT_I);
                d_ack = gnt_cyc_c && (grant == GNT_D);
            end else if (timeout_c) begin
                i_err = gnt_cyc_c && (grant == GNT_I);
                d_err = gnt_cyc_c && (grant == GNT_D);
            end
        end
    end

    // Request payload mux toward the slave
    always_comb begin
        s_adr = i_adr;
        s_we  = 1'b0;
        s_sel = {SW{1'b1}};
        s_dat = '0;
        if (grant == GNT_D) begin
            s_adr = d_adr;
            s_we  = d_we;
            s_sel = d_sel;
            s_dat = d_dat;
        end
    end

    assign i_rdt = DW'(s_rdt);
    assign d_rdt = DW'(s_rdt);

endmodule

// File: tb/tb_spi_sram_arbiter.sv
// Directed bench for spi_sram_arbiter: vector table for single transfers plus
// hand sequences for fairness, timeout, dropped requests and mid-transfer reset.
module tb_spi_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_cyc;
    logic [13:0] i_adr;
    logic [31:0] i_rdt;
    logic        i_ack;
    logic        i_err;
    logic        d_cyc;
    logic [13:0] d_adr;
    logic        d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_dat;
    logic [31:0] d_rdt;
    logic        d_ack;
    logic        d_err;
    logic        s_cyc;
    logic [13:0] s_adr;
    logic        s_we;
    logic [3:0]  s_sel;
    logic [31:0] s_dat;
    logic [31:0] s_rdt;
    logic        s_ack;
    logic        busy;

    int errors = 0;
    int checks = 0;

    spi_sram_arbiter #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst),
        .i_cyc(i_cyc), .i_adr(i_adr), .i_rdt(i_rdt), .i_ack(i_ack), .i_err(i_err),
        .d_cyc(d_cyc), .d_adr(d_adr), .d_we(d_we), .d_sel(d_sel), .d_dat(d_dat),
        .d_rdt(d_rdt), .d_ack(d_ack), .d_err(d_err),
        .s_cyc(s_cyc), .s_adr(s_adr), .s_we(s_we), .s_sel(s_sel), .s_dat(s_dat),
        .s_rdt(s_rdt), .s_ack(s_ack),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ic;
        logic        dc;
        logic        we;
        logic [13:0] ia;
        logic [13:0] da;
        logic [3:0]  sel;
        logic [31:0] dat;
        int          dly;
        logic [31:0] rdt;
        logic        exp_d;
        logic [13:0] exp_adr;
        logic        exp_we;
        logic [3:0]  exp_sel;
        logic [31:0] exp_dat;
    } vec_t;

    vec_t vecs[6];

    function automatic vec_t mk(input logic ic, input logic dc, input logic we,
                                input logic [13:0] ia, input logic [13:0] da,
                                input logic [3:0] sel, input logic [31:0] dat,
                                input int dly, input logic [31:0] rdt,
                                input logic ed, input logic [13:0] ea, input logic ew,
                                input logic [3:0] es, input logic [31:0] edat);
        vec_t v;
        v.ic = ic; v.dc = dc; v.we = we; v.ia = ia; v.da = da; v.sel = sel;
        v.dat = dat; v.dly = dly; v.rdt = rdt; v.exp_d = ed; v.exp_adr = ea;
        v.exp_we = ew; v.exp_sel = es; v.exp_dat = edat;
        return v;
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transfer from IDLE: request, grant, optional wait, ack, release
    task automatic run_vec(input vec_t v, input int idx);
        logic any;
        any   = 1'b0;
        i_cyc = v.ic; d_cyc = v.dc; i_adr = v.ia; d_adr = v.da;
        d_we  = v.we; d_sel = v.sel; d_dat = v.dat;
        #1;
        chk1($sformatf("v%0d_idle_scyc", idx), s_cyc, 1'b0);
        tick();
        chk1($sformatf("v%0d_scyc", idx), s_cyc, 1'b1);
        chk32($sformatf("v%0d_adr", idx), 32'(s_adr), 32'(v.exp_adr));
        chk1($sformatf("v%0d_we", idx), s_we, v.exp_we);
        chk32($sformatf("v%0d_sel", idx), 32'(s_sel), 32'(v.exp_sel));
        chk32($sformatf("v%0d_dat", idx), s_dat, v.exp_dat);
        for (int n = 0; n < v.dly; n++) begin
            any = any | i_ack | d_ack | i_err | d_err;
            tick();
        end
        chk1($sformatf("v%0d_early", idx), any, 1'b0);
        s_ack = 1'b1;
        s_rdt = v.rdt;
        #1;
        chk1($sformatf("v%0d_i_ack", idx), i_ack, ~v.exp_d);
        chk1($sformatf("v%0d_d_ack", idx), d_ack, v.exp_d);
        chk1($sformatf("v%0d_err", idx), i_err | d_err, 1'b0);
        chk32($sformatf("v%0d_rdt", idx), v.exp_d ? d_rdt : i_rdt, v.rdt);
        tick();
        s_ack = 1'b0; i_cyc = 1'b0; d_cyc = 1'b0;
        #1;
        chk1($sformatf("v%0d_rel_scyc", idx), s_cyc, 1'b0);
        chk1($sformatf("v%0d_rel_busy", idx), busy, 1'b1);
        tick();
        chk1($sformatf("v%0d_idle_busy", idx), busy, 1'b0);
    endtask

    // dbus write the slave never acks, optionally acked exactly at the timeout cycle
    task automatic run_timeout(input logic ack_at_to);
        int err_at;
        int ack_at;
        err_at = -1;
        ack_at = -1;
        d_cyc = 1'b1; d_we = 1'b1; d_sel = 4'b0011; d_dat = 32'h12345678; d_adr = 14'h0042;
        #1;
        tick();
        chk32("to_sel", 32'(s_sel), 32'h3);
        chk32("to_dat", s_dat, 32'h12345678);
        chk1("to_we", s_we, 1'b1);
        for (int k = 0; k <= 100; k++) begin
            if (k == 100 && ack_at_to) s_ack = 1'b1;
            #1;
            if (d_err && err_at < 0) err_at = k;
            if (d_ack && ack_at < 0) ack_at = k;
            if (k < 100) tick();
        end
        if (ack_at_to) begin
            chk32("to_ack_at", 32'(ack_at), 32'd100);
            chk32("to_no_err", 32'(err_at), 32'hFFFF_FFFF);
        end else begin
            chk32("to_err_at", 32'(err_at), 32'd100);
            chk32("to_no_ack", 32'(ack_at), 32'hFFFF_FFFF);
        end
        tick();
        s_ack = 1'b0; d_cyc = 1'b0;
        #1;
        chk1("to_rel_scyc", s_cyc, 1'b0);
        chk1("to_rel_err", d_err, 1'b0);
        tick();
        chk1("to_idle_busy", busy, 1'b0);
    endtask

    initial begin
        logic exp_d;
        logic all_high;

        vecs[0] = mk(1, 0, 0, 14'h0010, 14'h0000, 4'h0, 32'h0, 60, 32'hDEADBEEF,
                     0, 14'h0010, 0, 4'hF, 32'h0);
        vecs[1] = mk(0, 1, 1, 14'h0000, 14'h0123, 4'b0011, 32'h12345678, 3, 32'h0,
                     1, 14'h0123, 1, 4'b0011, 32'h12345678);
        vecs[2] = mk(1, 1, 1, 14'h0ABC, 14'h0DEF, 4'hF, 32'hAAAA5555, 2, 32'h01234567,
                     0, 14'h0ABC, 0, 4'hF, 32'h0);
        vecs[3] = mk(1, 1, 0, 14'h0111, 14'h3FFF, 4'b1100, 32'hCAFEF00D, 1, 32'h89ABCDEF,
                     1, 14'h3FFF, 0, 4'b1100, 32'hCAFEF00D);
        vecs[4] = mk(0, 1, 1, 14'h0000, 14'h2000, 4'b1000, 32'hFFFF0000, 0, 32'h55AA55AA,
                     1, 14'h2000, 1, 4'b1000, 32'hFFFF0000);
        vecs[5] = mk(1, 1, 1, 14'h1234, 14'h0001, 4'b0001, 32'h00000001, 4, 32'hFEEDFACE,
                     0, 14'h1234, 0, 4'hF, 32'h0);

        rst = 1'b1;
        i_cyc = 1'b0; i_adr = '0; d_cyc = 1'b0; d_adr = '0; d_we = 1'b0;
        d_sel = '0; d_dat = '0; s_rdt = '0; s_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset holds everything quiet even with requests and a stray slave ack
        i_cyc = 1'b1; d_cyc = 1'b1; s_ack = 1'b1;
        d_we = 1'b1; d_adr = 14'h0200; i_adr = 14'h0100;
        #1;
        chk1("rst_scyc", s_cyc, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_i_ack", i_ack, 1'b0);
        chk1("rst_d_ack", d_ack, 1'b0);
        chk1("rst_i_err", i_err, 1'b0);
        chk1("rst_d_err", d_err, 1'b0);
        s_ack = 1'b0;

        // Both masters request continuously: D,I,D,I with a two-cycle gap after each ack
        tick();
        rst = 1'b0;
        #1;
        chk1("a_idle_scyc", s_cyc, 1'b0);
        tick();
        for (int t = 0; t < 4; t++) begin
            exp_d = (t % 2 == 0);
            #1;
            chk1($sformatf("a%0d_scyc", t), s_cyc, 1'b1);
            chk1($sformatf("a%0d_we", t), s_we, exp_d);
            chk32($sformatf("a%0d_adr", t), 32'(s_adr), exp_d ? 32'h0200 : 32'h0100);
            tick();
            tick();
            s_ack = 1'b1;
            s_rdt = 32'h100 + 32'(t);
            #1;
            chk1($sformatf("a%0d_d_ack", t), d_ack, exp_d);
            chk1($sformatf("a%0d_i_ack", t), i_ack, ~exp_d);
            tick();
            s_ack = 1'b0;
            if (t == 3) begin
                i_cyc = 1'b0;
                d_cyc = 1'b0;
            end
            #1;
            chk1($sformatf("a%0d_rel_scyc", t), s_cyc, 1'b0);
            chk1($sformatf("a%0d_rel_busy", t), busy, 1'b1);
            tick();
            chk1($sformatf("a%0d_idle_scyc", t), s_cyc, 1'b0);
            chk1($sformatf("a%0d_idle_busy", t), busy, 1'b0);
            tick();
        end

        for (int v = 0; v < 6; v++) begin
            run_vec(vecs[v], v);
        end

        run_timeout(1'b1);
        run_timeout(1'b0);

        // Granted dbus drops cyc; pending ibus must wait and see nothing until granted
        d_cyc = 1'b1; d_we = 1'b0; d_adr = 14'h0777; i_adr = 14'h0555;
        #1;
        tick();
        i_cyc = 1'b1;
        #1;
        chk32("c_adr_d", 32'(s_adr), 32'h0777);
        tick();
        tick();
        d_cyc = 1'b0;
        all_high = 1'b1;
        for (int n = 0; n < 3; n++) begin
            #1;
            all_high = all_high & s_cyc;
            tick();
        end
        chk1("c_scyc_held", all_high & s_cyc, 1'b1);
        s_ack = 1'b1;
        #1;
        chk1("c_d_ack_supp", d_ack, 1'b0);
        chk1("c_i_ack_pend", i_ack, 1'b0);
        chk1("c_d_err_supp", d_err, 1'b0);
        tick();
        chk1("c_rel_scyc", s_cyc, 1'b0);
        chk1("c_rel_ack_ign", i_ack | d_ack, 1'b0);
        s_ack = 1'b0;
        tick();
        chk1("c_gap_scyc", s_cyc, 1'b0);
        tick();
        chk1("c_i_scyc", s_cyc, 1'b1);
        chk32("c_i_adr", 32'(s_adr), 32'h0555);
        chk1("c_i_we", s_we, 1'b0);
        s_ack = 1'b1;
        s_rdt = 32'h0BADF00D;
        #1;
        chk1("c_i_ack", i_ack, 1'b1);
        chk32("c_i_rdt", i_rdt, 32'h0BADF00D);
        tick();
        s_ack = 1'b0; i_cyc = 1'b0;
        tick();
        s_ack = 1'b1;
        #1;
        chk1("c_idle_ack_ign", i_ack | d_ack, 1'b0);
        s_ack = 1'b0;

        // Reset in mid-transfer, then the first tie afterwards goes to dbus again
        d_cyc = 1'b1; d_we = 1'b1; d_adr = 14'h0099;
        #1;
        tick();
        tick();
        chk1("d_scyc_pre", s_cyc, 1'b1);
        rst = 1'b1;
        s_ack = 1'b1;
        #1;
        chk1("d_rst_scyc", s_cyc, 1'b0);
        chk1("d_rst_busy", busy, 1'b0);
        chk1("d_rst_ack", d_ack, 1'b0);
        chk1("d_rst_err", d_err, 1'b0);
        tick();
        rst = 1'b0; s_ack = 1'b0; i_cyc = 1'b1;
        #1;
        chk1("d_post_idle", s_cyc, 1'b0);
        tick();
        chk1("d_post_scyc", s_cyc, 1'b1);
        chk1("d_post_we", s_we, 1'b1);
        chk32("d_post_adr", 32'(s_adr), 32'h0099);
        s_ack = 1'b1;
        #1;
        chk1("d_post_ack", d_ack, 1'b1);
        tick();
        s_ack = 1'b0; i_cyc = 1'b0; d_cyc = 1'b0;
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
